// File: rtl/register_file.sv
// register_file
//
// Architectural integer register file for the out-of-order core. It holds the
// 32 RV32I registers, and each register also has a busy bit and the ROB tag
// of its newest in-flight producer.
//
// Ports:
//   Sys_clk, Sys_rst      clock and synchronous active-high reset
//   Sys_rdy               global enable; when low, state holds and inputs are ignored
//   DP2RF_rs1/rs2         dispatcher source indices (combinational read)
//   DP2RF_en/rd/ROB_index destination rename recorded at dispatch
//   RF2DP_Qj/Qk           dependency tags; MSB=1 means ready
//   RF2DP_Vj/Vk           operand values
//   ROB2RF_pre_judge      misprediction flush; drops every outstanding rename
//   ROB2RF_en/ROB_index/rd/value  commit of a retired result
//
// Optional feature: define RF_COMMIT_BYPASS_EN to forward a matching commit
// to the read ports in the same cycle.

module register_file #(
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned EX_REG_WIDTH = 6,
    parameter int unsigned ROB_WIDTH    = 4,
    parameter int unsigned EX_ROB_WIDTH = 5
) (
    input  logic                    Sys_clk,
    input  logic                    Sys_rst,
    input  logic                    Sys_rdy,

    input  logic [REG_WIDTH-1:0]    DP2RF_rs1,
    input  logic [REG_WIDTH-1:0]    DP2RF_rs2,
    input  logic                    DP2RF_en,
    input  logic [EX_REG_WIDTH-1:0] DP2RF_rd,
    input  logic [ROB_WIDTH-1:0]    DP2RF_ROB_index,

    output logic [EX_ROB_WIDTH-1:0] RF2DP_Qj,
    output logic [EX_ROB_WIDTH-1:0] RF2DP_Qk,
    output logic [31:0]             RF2DP_Vj,
    output logic [31:0]             RF2DP_Vk,

    input  logic                    ROB2RF_pre_judge,
    input  logic                    ROB2RF_en,
    input  logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index,
    input  logic [EX_REG_WIDTH-1:0] ROB2RF_rd,
    input  logic [31:0]             ROB2RF_value
);

    localparam int unsigned NumRegs = 1 << REG_WIDTH;

    localparam logic [EX_ROB_WIDTH-1:0] TagReady = {1'b1, {ROB_WIDTH{1'b0}}};

    logic [31:0]          value_q [NumRegs];
    logic [31:0]          value_d [NumRegs];
    logic [NumRegs-1:0]   busy_q;
    logic [NumRegs-1:0]   busy_d;
    logic [ROB_WIDTH-1:0] tag_q   [NumRegs];
    logic [ROB_WIDTH-1:0] tag_d   [NumRegs];

    logic [REG_WIDTH-1:0] dp_rd_idx;
    logic [REG_WIDTH-1:0] cm_rd_idx;
    logic                 rename_valid;
    logic                 commit_valid;
    logic                 flush;

    // The destination MSB flags "no destination", and writes to x0 are
    // dropped here so that x0 never holds any state.
    assign dp_rd_idx    = DP2RF_rd[REG_WIDTH-1:0];
    assign cm_rd_idx    = ROB2RF_rd[REG_WIDTH-1:0];
    assign rename_valid = Sys_rdy & DP2RF_en & ~DP2RF_rd[EX_REG_WIDTH-1] & (dp_rd_idx != '0);
    assign commit_valid = Sys_rdy & ROB2RF_en & ~ROB2RF_rd[EX_REG_WIDTH-1] & (cm_rd_idx != '0);
    assign flush        = Sys_rdy & ROB2RF_pre_judge;

    // Next-state logic
    always_comb begin
        for (int i = 0; i < NumRegs; i++) begin
            value_d[i] = value_q[i];
            busy_d[i]  = busy_q[i];
            tag_d[i]   = tag_q[i];
        end
        for (int i = 1; i < NumRegs; i++) begin
            if (commit_valid && (cm_rd_idx == REG_WIDTH'(i))) begin
                value_d[i] = ROB2RF_value;
                // A tag mismatch means a younger rename is still outstanding.
                if (tag_q[i] == ROB2RF_ROB_index) begin
                    busy_d[i] = 1'b0;
                end
            end
            // A flush squashes every rename, including one in this cycle.
            // Otherwise a rename takes priority over a same-cycle commit
            // when the commit would clear the busy bit.
            if (flush) begin
                busy_d[i] = 1'b0;
            end else if (rename_valid && (dp_rd_idx == REG_WIDTH'(i))) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = DP2RF_ROB_index;
            end
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            // The valid/flush strobes above already include Sys_rdy.
            for (int i = 0; i < NumRegs; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports. Reads see the registered state, so a rename in this cycle
    // does not affect them.
    logic [REG_WIDTH-1:0]    rs_idx [2];
    logic [EX_ROB_WIDTH-1:0] rd_q   [2];
    logic [31:0]             rd_v   [2];

    assign rs_idx[0] = DP2RF_rs1;
    assign rs_idx[1] = DP2RF_rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_v[p] = value_q[rs_idx[p]];
            if (busy_q[rs_idx[p]]) begin
                rd_q[p] = {1'b0, tag_q[rs_idx[p]]};
            end else begin
                rd_q[p] = TagReady;
            end
`ifdef RF_COMMIT_BYPASS_EN
            // Forward the committing result only when it comes from the
            // newest producer. commit_valid already excludes x0.
            if (commit_valid && (cm_rd_idx == rs_idx[p]) && busy_q[rs_idx[p]] &&
                (tag_q[rs_idx[p]] == ROB2RF_ROB_index)) begin
                rd_q[p] = TagReady;
                rd_v[p] = ROB2RF_value;
            end
`endif
        end
    end

    assign RF2DP_Qj = rd_q[0];
    assign RF2DP_Qk = rd_q[1];
    assign RF2DP_Vj = rd_v[0];
    assign RF2DP_Vk = rd_v[1];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;

    logic        Sys_clk = 1'b0;
    logic        Sys_rst;
    logic        Sys_rdy;
    logic [4:0]  DP2RF_rs1;
    logic [4:0]  DP2RF_rs2;
    logic        DP2RF_en;
    logic [5:0]  DP2RF_rd;
    logic [3:0]  DP2RF_ROB_index;
    logic [4:0]  RF2DP_Qj;
    logic [4:0]  RF2DP_Qk;
    logic [31:0] RF2DP_Vj;
    logic [31:0] RF2DP_Vk;
    logic        ROB2RF_pre_judge;
    logic        ROB2RF_en;
    logic [3:0]  ROB2RF_ROB_index;
    logic [5:0]  ROB2RF_rd;
    logic [31:0] ROB2RF_value;

    int tests = 0;
    int fails = 0;

    register_file dut (
        .Sys_clk          (Sys_clk),
        .Sys_rst          (Sys_rst),
        .Sys_rdy          (Sys_rdy),
        .DP2RF_rs1        (DP2RF_rs1),
        .DP2RF_rs2        (DP2RF_rs2),
        .DP2RF_en         (DP2RF_en),
        .DP2RF_rd         (DP2RF_rd),
        .DP2RF_ROB_index  (DP2RF_ROB_index),
        .RF2DP_Qj         (RF2DP_Qj),
        .RF2DP_Qk         (RF2DP_Qk),
        .RF2DP_Vj         (RF2DP_Vj),
        .RF2DP_Vk         (RF2DP_Vk),
        .ROB2RF_pre_judge (ROB2RF_pre_judge),
        .ROB2RF_en        (ROB2RF_en),
        .ROB2RF_ROB_index (ROB2RF_ROB_index),
        .ROB2RF_rd        (ROB2RF_rd),
        .ROB2RF_value     (ROB2RF_value)
    );

    always #5 Sys_clk = ~Sys_clk;

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic idle();
        Sys_rst          = 1'b0;
        Sys_rdy          = 1'b1;
        DP2RF_en         = 1'b0;
        DP2RF_rd         = 6'd0;
        DP2RF_ROB_index  = 4'd0;
        ROB2RF_pre_judge = 1'b0;
        ROB2RF_en        = 1'b0;
        ROB2RF_ROB_index = 4'd0;
        ROB2RF_rd        = 6'd0;
        ROB2RF_value     = 32'd0;
    endtask

    task automatic tick();
        @(posedge Sys_clk);
        #1;
        idle();
    endtask

    task automatic rename(input logic [5:0] rd, input logic [3:0] idx);
        DP2RF_en        = 1'b1;
        DP2RF_rd        = rd;
        DP2RF_ROB_index = idx;
    endtask

    task automatic commit(input logic [5:0] rd, input logic [3:0] idx, input logic [31:0] val);
        ROB2RF_en        = 1'b1;
        ROB2RF_rd        = rd;
        ROB2RF_ROB_index = idx;
        ROB2RF_value     = val;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        DP2RF_rs1 = a;
        DP2RF_rs2 = b;
        #1;
    endtask

    task automatic test_reset();
        idle();
        Sys_rst = 1'b1;
        rename(6'd5, 4'd3);          // the reset must override this rename
        tick();
        read(5'd5, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL reset_qj got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Qk !== 5'b10000) begin fails++; $display("FAIL reset_qk got %b exp %b", RF2DP_Qk, 5'b10000); end
        tests++; if (RF2DP_Vj !== 32'd0) begin fails++; $display("FAIL reset_vj got %h exp %h", RF2DP_Vj, 32'd0); end
        tests++; if (RF2DP_Vk !== 32'd0) begin fails++; $display("FAIL reset_vk got %h exp %h", RF2DP_Vk, 32'd0); end
    endtask

    task automatic test_rename_commit();
        rename(6'd3, 4'd7);
        read(5'd3, 5'd0);
        // the read sees the state before this cycle's rename
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL no_rename_bypass got %b exp %b", RF2DP_Qj, 5'b10000); end
        tick();
        read(5'd3, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b00111) begin fails++; $display("FAIL rename_tag got %b exp %b", RF2DP_Qj, 5'b00111); end
        commit(6'd3, 4'd7, 32'hDEADBEEF);
        tick();
        read(5'd3, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL commit_ready got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vj !== 32'hDEADBEEF) begin fails++; $display("FAIL commit_value got %h exp %h", RF2DP_Vj, 32'hDEADBEEF); end
    endtask

    task automatic test_no_dest();
        // The MSB of rd set means no destination: x3 must be left unchanged.
        rename(6'b100011, 4'd1);
        commit(6'b100011, 4'd1, 32'h1);
        tick();
        read(5'd0, 5'd3);
        tests++; if (RF2DP_Qk !== 5'b10000) begin fails++; $display("FAIL nodest_q got %b exp %b", RF2DP_Qk, 5'b10000); end
        tests++; if (RF2DP_Vk !== 32'hDEADBEEF) begin fails++; $display("FAIL nodest_v got %h exp %h", RF2DP_Vk, 32'hDEADBEEF); end
    endtask

    task automatic test_stale_commit();
        rename(6'd4, 4'd2);
        tick();
        rename(6'd4, 4'd5);
        tick();
        commit(6'd4, 4'd2, 32'h11);
        tick();
        read(5'd4, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b00101) begin fails++; $display("FAIL stale_busy got %b exp %b", RF2DP_Qj, 5'b00101); end
        tests++; if (RF2DP_Vj !== 32'h11) begin fails++; $display("FAIL stale_value got %h exp %h", RF2DP_Vj, 32'h11); end
        commit(6'd4, 4'd5, 32'h22);
        tick();
        read(5'd4, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL young_ready got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vj !== 32'h22) begin fails++; $display("FAIL young_value got %h exp %h", RF2DP_Vj, 32'h22); end
    endtask

    task automatic test_back_to_back();
        // Rename and commit to the same register in the same cycle.
        rename(6'd6, 4'd9);
        commit(6'd6, 4'd1, 32'h33);
        tick();
        read(5'd0, 5'd6);
        tests++; if (RF2DP_Qk !== 5'b01001) begin fails++; $display("FAIL same_cycle_tag got %b exp %b", RF2DP_Qk, 5'b01001); end
        // flush makes the stored value visible as ready
        ROB2RF_pre_judge = 1'b1;
        tick();
        read(5'd0, 5'd6);
        tests++; if (RF2DP_Vk !== 32'h33) begin fails++; $display("FAIL same_cycle_value got %h exp %h", RF2DP_Vk, 32'h33); end
    endtask

    task automatic test_flush();
        rename(6'd1, 4'd3);
        tick();
        rename(6'd2, 4'd4);
        tick();
        read(5'd1, 5'd2);
        tests++; if (RF2DP_Qj !== 5'b00011) begin fails++; $display("FAIL pre_flush_x1 got %b exp %b", RF2DP_Qj, 5'b00011); end
        tests++; if (RF2DP_Qk !== 5'b00100) begin fails++; $display("FAIL pre_flush_x2 got %b exp %b", RF2DP_Qk, 5'b00100); end
        ROB2RF_pre_judge = 1'b1;
        rename(6'd7, 4'd6);
        commit(6'd10, 4'd0, 32'h0000ABCD);
        tick();
        read(5'd1, 5'd2);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL flush_x1 got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Qk !== 5'b10000) begin fails++; $display("FAIL flush_x2 got %b exp %b", RF2DP_Qk, 5'b10000); end
        read(5'd7, 5'd10);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL flush_x7 got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vk !== 32'h0000ABCD) begin fails++; $display("FAIL flush_commit got %h exp %h", RF2DP_Vk, 32'h0000ABCD); end
    endtask

    task automatic test_x0();
        rename(6'd0, 4'd8);
        commit(6'd0, 4'd8, 32'hFFFF_FFFF);
        tick();
        read(5'd0, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL x0_q got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vj !== 32'd0) begin fails++; $display("FAIL x0_v got %h exp %h", RF2DP_Vj, 32'd0); end
    endtask

    task automatic test_sys_rdy();
        Sys_rdy = 1'b0;
        rename(6'd11, 4'd2);
        commit(6'd10, 4'd0, 32'h12345678);
        tick();
        read(5'd11, 5'd10);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL rdy_rename got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vk !== 32'h0000ABCD) begin fails++; $display("FAIL rdy_commit got %h exp %h", RF2DP_Vk, 32'h0000ABCD); end
    endtask

    task automatic test_bypass();
        rename(6'd8, 4'd10);
        tick();
        commit(6'd8, 4'd10, 32'h55);
        read(5'd8, 5'd0);
`ifdef RF_COMMIT_BYPASS_EN
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL bypass_q got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vj !== 32'h55) begin fails++; $display("FAIL bypass_v got %h exp %h", RF2DP_Vj, 32'h55); end
`else
        tests++; if (RF2DP_Qj !== 5'b01010) begin fails++; $display("FAIL nobypass_q got %b exp %b", RF2DP_Qj, 5'b01010); end
`endif
        tick();
        read(5'd8, 5'd0);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL post_commit_q got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vj !== 32'h55) begin fails++; $display("FAIL post_commit_v got %h exp %h", RF2DP_Vj, 32'h55); end
    endtask

    task automatic test_reset_mid();
        rename(6'd12, 4'd1);
        tick();
        Sys_rst = 1'b1;
        commit(6'd3, 4'd0, 32'h77);  // the reset must override this commit
        tick();
        read(5'd12, 5'd3);
        tests++; if (RF2DP_Qj !== 5'b10000) begin fails++; $display("FAIL midrst_tag got %b exp %b", RF2DP_Qj, 5'b10000); end
        tests++; if (RF2DP_Vk !== 32'd0) begin fails++; $display("FAIL midrst_value got %h exp %h", RF2DP_Vk, 32'd0); end
    endtask

    initial begin
        DP2RF_rs1 = 5'd0;
        DP2RF_rs2 = 5'd0;
        idle();
        #1;
        test_reset();
        test_rename_commit();
        test_no_dest();
        test_stale_commit();
        test_back_to_back();
        test_flush();
        test_x0();
        test_sys_rdy();
        test_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
